// File: rtl/btn_conditioner.sv
// Alarm-clock key conditioner: synchronises, debounces and cleans up the four
// raw push-buttons before they reach the processor PIO inputs. The up and down
// keys also get hold-to-repeat, so polling software can step values quickly.
//
// Repeat FSM (one per up/down channel)
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | key not pressed, or up and down both pressed; output 0
//   ST_HELD    | fresh press, waiting out the hold delay; output 1
//   ST_RPT_OFF | auto-repeat, low half-period; output 0
//   ST_RPT_ON  | auto-repeat, high half-period; output 1
module btn_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned HOLD_CYCLES     = 25000000,
   parameter int unsigned REPEAT_CYCLES   = 5000000,
   parameter bit          ACTIVE_LOW_IN   = 1'b1
) (
   input  logic clk_clk,
   input  logic reset_reset_n,
   input  logic key_set_clock,
   input  logic key_set_alarm,
   input  logic key_up,
   input  logic key_down,
   output logic btn_set_clock,
   output logic btn_set_alarm,
   output logic btn_up,
   output logic btn_down
);

   // Released raw level, so a key held through reset is seen as a new press.
   localparam logic [3:0] RAW_IDLE = ACTIVE_LOW_IN ? 4'hF : 4'h0;

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   localparam int unsigned HALF = REPEAT_CYCLES / 2;
   localparam int unsigned TMAX = (HOLD_CYCLES > HALF) ? HOLD_CYCLES : HALF;
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HELD    = 2'd1,
      ST_RPT_OFF = 2'd2,
      ST_RPT_ON  = 2'd3
   } rpt_state_t;

   // Bit order everywhere: 0 set_clock, 1 set_alarm, 2 up, 3 down.
   logic [3:0] w_raw;
   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [3:0] w_pressed_sync;
   logic [3:0] w_stable;
   logic [1:0] w_rpt_out;
   logic       w_both;

   assign w_raw = {key_down, key_up, key_set_alarm, key_set_clock};

   // Two-flop synchroniser for the asynchronous raw keys.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_sync1 <= RAW_IDLE;
         r_sync2 <= RAW_IDLE;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_pressed_sync = ACTIVE_LOW_IN ? ~r_sync2 : r_sync2;

   for (genvar g = 0; g < 4; g++) begin : g_db
      logic [DW-1:0] r_cnt;
      logic          r_stable;

      // Accept a new level only after it has been seen for DEBOUNCE_CYCLES in a row.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
         end else if (w_pressed_sync[g] == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == DB_LAST) begin
            r_cnt    <= '0;
            r_stable <= w_pressed_sync[g];
         end else begin
            r_cnt <= r_cnt + DW'(1);
         end
      end

      assign w_stable[g] = r_stable;
   end

   // Up and down together is ambiguous; neither repeats while both are held.
   assign w_both = w_stable[2] & w_stable[3];

   for (genvar j = 0; j < 2; j++) begin : g_rpt
      rpt_state_t    r_state;
      rpt_state_t    w_state_nxt;
      logic [TW-1:0] r_timer;
      logic [TW-1:0] w_timer_nxt;
      logic          r_out;
      logic          w_key;

      assign w_key = w_stable[2 + j];

      // State, timer and output register; output decoded from next state so it is a flop.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_out   <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_out   <= (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RPT_ON);
         end
      end

      // Next-state: hold delay, then a square wave starting with the low half.
      always_comb begin
         w_state_nxt = r_state;
         w_timer_nxt = r_timer + TW'(1);
         if (!w_key || w_both) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  w_state_nxt = ST_HELD;
                  w_timer_nxt = '0;
               end
               ST_HELD: begin
                  if (r_timer == HOLD_LAST) begin
                     w_state_nxt = ST_RPT_OFF;
                     w_timer_nxt = '0;
                  end
               end
               ST_RPT_OFF: begin
                  if (r_timer == HALF_LAST) begin
                     w_state_nxt = ST_RPT_ON;
                     w_timer_nxt = '0;
                  end
               end
               ST_RPT_ON: begin
                  if (r_timer == HALF_LAST) begin
                     w_state_nxt = ST_RPT_OFF;
                     w_timer_nxt = '0;
                  end
               end
               default: begin
                  w_state_nxt = ST_IDLE;
                  w_timer_nxt = '0;
               end
            endcase
         end
      end

      assign w_rpt_out[j] = r_out;
   end

   assign btn_set_clock = w_stable[0];
   assign btn_set_alarm = w_stable[1];
   assign btn_up        = w_rpt_out[0];
   assign btn_down      = w_rpt_out[1];

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: expected output vectors are computed from the
// timing rules, queued per cycle when a key is driven, and compared when the
// cycle comes around.
module tb_btn_conditioner;

   localparam int DB   = 4;
   localparam int HOLD = 20;
   localparam int RPT  = 8;
   localparam int HALF = RPT / 2;
   localparam int INF  = 1 << 30;

   logic clk_clk = 1'b0;
   logic reset_reset_n;
   logic key_set_clock, key_set_alarm, key_up, key_down;
   logic btn_set_clock, btn_set_alarm, btn_up, btn_down;
   logic [3:0] btn_vec;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   typedef struct {
      int         due;
      logic [3:0] val;
      string      tag;
   } exp_t;

   exp_t sb_q[$];

   btn_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .HOLD_CYCLES    (HOLD),
      .REPEAT_CYCLES  (RPT),
      .ACTIVE_LOW_IN  (1'b1)
   ) dut (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .key_set_clock(key_set_clock),
      .key_set_alarm(key_set_alarm),
      .key_up       (key_up),
      .key_down     (key_down),
      .btn_set_clock(btn_set_clock),
      .btn_set_alarm(btn_set_alarm),
      .btn_up       (btn_up),
      .btn_down     (btn_down)
   );

   assign btn_vec = {btn_down, btn_up, btn_set_alarm, btn_set_clock};

   always #5 clk_clk = ~clk_clk;

   always @(posedge clk_clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push_exp(input int due, input logic [3:0] val, input string tag);
      exp_t e;
      e.due = due;
      e.val = val;
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   // Expected repeat-channel level: high for HOLD cycles from rise, then low/high halves.
   function automatic logic rpt_exp(input int t, input int rise, input int fall);
      int d;
      if (t < rise || t >= fall) return 1'b0;
      d = t - rise;
      if (d < HOLD) return 1'b1;
      return (((d - HOLD) / HALF) % 2) == 1;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   // Scoreboard: compare every entry due at this cycle, away from the active edge.
   always @(negedge clk_clk) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].due == cyc) begin
            check_eq($sformatf("%s@%0d", sb_q[i].tag, cyc), {28'd0, btn_vec}, {28'd0, sb_q[i].val});
            sb_q.delete(i);
         end
      end
   end

   initial begin
      int p, q, d, u, v, r;

      reset_reset_n = 1'b0;
      key_set_clock = 1'b1;
      key_set_alarm = 1'b1;
      key_up        = 1'b1;
      key_down      = 1'b1;

      // Reset values
      tick(4);
      check_eq("rst_hold", {28'd0, btn_vec}, 32'd0);
      reset_reset_n = 1'b1;
      p = cyc;
      for (int t = p + 1; t <= p + 50; t++) push_exp(t, 4'b0000, "rst_idle");
      tick(52);

      // Clean press and release of set_clock
      p = cyc;
      key_set_clock = 1'b0;
      for (int t = p + 1; t <= p + 20; t++) push_exp(t, {3'b000, t >= p + 1 + DB + 1}, "set_press");
      tick(20);
      q = cyc;
      key_set_clock = 1'b1;
      for (int t = q + 1; t <= q + 12; t++) push_exp(t, {3'b000, t < q + 1 + DB + 1}, "set_release");
      tick(14);

      // Bounce rejection on set_alarm
      p = cyc;
      for (int t = p + 1; t <= p + 40; t++) push_exp(t, 4'b0000, "bounce");
      for (int i = 0; i < 15; i++) begin
         key_set_alarm = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick(2);
      end
      key_set_alarm = 1'b1;
      tick(12);

      // Auto-repeat on up
      p = cyc;
      key_up = 1'b0;
      for (int t = p + 1; t <= p + 60; t++)
         push_exp(t, {1'b0, rpt_exp(t, p + 7, p + 67), 2'b00}, "rpt_hold");
      tick(60);
      q = cyc;
      key_up = 1'b1;
      for (int t = q + 1; t <= q + 15; t++)
         push_exp(t, {1'b0, rpt_exp(t, p + 7, q + 7), 2'b00}, "rpt_release");
      tick(17);

      // Up/down conflict, then down resumes as a fresh press
      p = cyc;
      key_up = 1'b0;
      for (int t = p + 1; t <= p + 10; t++)
         push_exp(t, {1'b0, rpt_exp(t, p + 7, p + 17), 2'b00}, "conf_up");
      tick(10);
      d = cyc;
      key_down = 1'b0;
      for (int t = d + 1; t <= d + 20; t++)
         push_exp(t, {1'b0, rpt_exp(t, p + 7, p + 17), 2'b00}, "conf_both");
      tick(20);
      u = cyc;
      v = u + 40;
      key_up = 1'b1;
      for (int t = u + 1; t <= u + 40; t++)
         push_exp(t, {rpt_exp(t, u + 7, v + 7), 3'b000}, "conf_down");
      tick(40);
      key_down = 1'b1;
      for (int t = v + 1; t <= v + 15; t++)
         push_exp(t, {rpt_exp(t, u + 7, v + 7), 3'b000}, "conf_down_rel");
      tick(17);

      // Reset mid-operation during RPT_ON, key held through reset release
      p = cyc;
      key_up = 1'b0;
      for (int t = p + 1; t <= p + 32; t++)
         push_exp(t, {1'b0, rpt_exp(t, p + 7, INF), 2'b00}, "mid_pre");
      tick(32);
      #2;
      reset_reset_n = 1'b0;
      #1;
      check_eq("rst_mid_async", {28'd0, btn_vec}, 32'd0);
      tick(3);
      check_eq("rst_mid_hold", {28'd0, btn_vec}, 32'd0);
      r = cyc;
      reset_reset_n = 1'b1;
      for (int t = r + 1; t <= r + 30; t++)
         push_exp(t, {1'b0, rpt_exp(t, r + 7, INF), 2'b00}, "mid_post");
      tick(30);
      q = cyc;
      key_up = 1'b1;
      for (int t = q + 1; t <= q + 12; t++)
         push_exp(t, {1'b0, rpt_exp(t, r + 7, q + 7), 2'b00}, "mid_release");
      tick(14);

      check_eq("sb_drain", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
